// File: rtl/wake_up_sequencer_pkg.sv
// Shared constants for the wake-up sequencer: core counts, release window size and release spacing.
package wake_up_sequencer_pkg;

    localparam int unsigned NumCores           = 256;
    localparam int unsigned NumCoresPerTile    = 4;
    localparam int unsigned WakeUpTilesPerStep = 1;
    localparam int unsigned WakeUpStepCycles   = 4;

    // Counter/index width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wake_up_sequencer_if.sv
// Wake-up request/pulse bundle between the control registers (master) and the sequencer (slave).
interface wake_up_sequencer_if
    import wake_up_sequencer_pkg::*;
#(
    parameter int unsigned NumCores = wake_up_sequencer_pkg::NumCores
);

    logic [NumCores-1:0] wake_up_i;
    logic [NumCores-1:0] wake_up_o;
    logic                busy_o;

    modport master (output wake_up_i, input wake_up_o, input busy_o);
    modport slave  (input wake_up_i, output wake_up_o, output busy_o);

endinterface

// File: rtl/wake_up_window_pick.sv
// Rotating find-first over the "window non-empty" bits, searching upward from start with wrap-around.
module wake_up_window_pick
    import wake_up_sequencer_pkg::*;
#(
    parameter int unsigned NumWindows = 64,
    parameter int unsigned IdxWidth   = min_width(NumWindows)
) (
    input  logic [NumWindows-1:0] nonempty,
    input  logic [IdxWidth-1:0]   start,
    output logic [IdxWidth-1:0]   idx,
    output logic                  valid
);

    localparam logic [IdxWidth:0] NumWin = (IdxWidth + 1)'(NumWindows);

    logic [NumWindows-1:0] rotated;
    logic [IdxWidth:0]     sum;

    // Rotate so that bit 0 is the window at start; the first set bit is then the round-robin winner.
    always_comb begin
        rotated = (nonempty >> start) | (nonempty << (NumWindows - 32'(start)));
        idx     = '0;
        valid   = 1'b0;
        sum     = '0;
        for (int i = 0; i < NumWindows; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                sum   = {1'b0, start} + (IdxWidth + 1)'(i);
                if (sum >= NumWin) begin
                    sum = sum - NumWin;
                end
                idx = sum[IdxWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/wake_up_sequencer.sv
// Staggers core wake-up requests, releasing one window of pending cores every StepCycles cycles.
// Optional macro WAKE_UP_SEQ_BROADCAST_EN: an all-ones request bypasses staggering.
module wake_up_sequencer
    import wake_up_sequencer_pkg::*;
#(
    parameter int unsigned NumCores        = wake_up_sequencer_pkg::NumCores,
    parameter int unsigned NumCoresPerTile = wake_up_sequencer_pkg::NumCoresPerTile,
    parameter int unsigned TilesPerStep    = WakeUpTilesPerStep,
    parameter int unsigned StepCycles      = WakeUpStepCycles
) (
    input logic                clk_i,
    input logic                rst_i,
    wake_up_sequencer_if.slave bus
);

    localparam int unsigned CoresPerWindow = NumCoresPerTile * TilesPerStep;
    localparam int unsigned NumWindows     = NumCores / CoresPerWindow;
    localparam int unsigned PtrWidth       = min_width(NumWindows);
    localparam int unsigned GapWidth       = min_width(StepCycles);

    localparam logic [GapWidth-1:0] GapLoad    = GapWidth'(StepCycles - 1);
    localparam logic [PtrWidth-1:0] LastWindow = PtrWidth'(NumWindows - 1);
    localparam logic [NumCores-1:0] WindowBase = NumCores'({CoresPerWindow{1'b1}});

    if ((NumCores % CoresPerWindow) != 0) begin : g_check_div
        $error("NumCores must be a multiple of NumCoresPerTile*TilesPerStep");
    end
    if (StepCycles < 1) begin : g_check_step
        $error("StepCycles must be at least 1");
    end

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    state_t              state_q;
    logic [NumCores-1:0] pending_q;
    logic [PtrWidth-1:0] ptr_q;
    logic [GapWidth-1:0] gap_cnt;
    logic [NumCores-1:0] wake_up_q;
    logic                busy_q;

    logic [NumWindows-1:0] nonempty;
    logic [PtrWidth-1:0]   pick_idx;
    logic                  pick_valid;
    logic                  release_en;
    logic [NumCores-1:0]   released;
    logic [NumCores-1:0]   pending_d;
    logic [PtrWidth-1:0]   ptr_next;
    logic                  broadcast;
    int unsigned           window_shift;

    for (genvar w = 0; w < NumWindows; w++) begin : g_nonempty
        assign nonempty[w] = |pending_q[w*CoresPerWindow +: CoresPerWindow];
    end

    wake_up_window_pick #(
        .NumWindows (NumWindows),
        .IdxWidth   (PtrWidth)
    ) i_window_pick (
        .nonempty (nonempty),
        .start    (ptr_q),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    assign window_shift = CoresPerWindow * 32'(pick_idx);
    assign release_en   = (state_q == IDLE) && pick_valid;
    assign released     = release_en ? (pending_q & (WindowBase << window_shift)) : '0;
    assign pending_d    = (pending_q & ~released) | bus.wake_up_i;
    assign ptr_next     = (pick_idx == LastWindow) ? '0 : pick_idx + 1'b1;

`ifdef WAKE_UP_SEQ_BROADCAST_EN
    assign broadcast = &bus.wake_up_i;
`else
    assign broadcast = 1'b0;
`endif

    // busy covers the request cycle's follow-up and the cycle after the final release,
    // so it is taken from the pre-release pending set rather than pending_d.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            gap_cnt   <= '0;
            wake_up_q <= '0;
            busy_q    <= 1'b0;
        end else if (broadcast) begin
            wake_up_q <= '1;
            pending_q <= '0;
            busy_q    <= 1'b0;
            gap_cnt   <= GapLoad;
            state_q   <= (GapLoad != '0) ? GAP : IDLE;
        end else begin
            pending_q <= pending_d;
            busy_q    <= |(pending_q | bus.wake_up_i);
            wake_up_q <= released;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        ptr_q   <= ptr_next;
                        gap_cnt <= GapLoad;
                        if (GapLoad != '0) begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt <= GapWidth'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wake_up_o = wake_up_q;
    assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_wake_up_sequencer.sv
// Self-checking bench for wake_up_sequencer: table-driven single requests plus multi-cycle corner sequences.
module tb_wake_up_sequencer;

    localparam int Cores   = 256;
    localparam int Cpw     = 4;
    localparam int Windows = 64;
    localparam int Step    = 4;
    localparam int NumVec  = 7;

    typedef logic [Cores-1:0] mask_t;

    typedef struct {
        int    cyc;
        mask_t mask;
    } pulse_t;

    typedef struct {
        string name;
        mask_t req;
        int    n_pulses;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wake_up_sequencer_if #(.NumCores(Cores)) bus_if ();

    wake_up_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int     cyc        = 0;
    int     checks     = 0;
    int     errors     = 0;
    int     pulse_seen = 0;
    int     busy_from  = 1;
    int     busy_to    = 0;
    pulse_t exp_q[$];
    mask_t  exp_mask;
    logic   exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input mask_t actual, input mask_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual=%h expected=%h", name, cyc, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s pulse count actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Every cycle: busy against its expected window, wake_up_o against the scoreboard head.
    always @(negedge clk) begin
        exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
        checkOutput("busy", mask_t'(bus_if.busy_o), mask_t'(exp_busy));
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_mask = exp_q[0].mask;
            void'(exp_q.pop_front());
        end else begin
            exp_mask = '0;
        end
        checkOutput("wake_up", bus_if.wake_up_o, exp_mask);
        if (bus_if.wake_up_o != '0) pulse_seen++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input mask_t req);
        bus_if.wake_up_i = req;
        idle(1);
        bus_if.wake_up_i = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    task automatic expectPulse(input int at, input mask_t m);
        exp_q.push_back('{cyc: at, mask: m});
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) idle(1);
        checkCount({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic mask_t windowMask(input int w);
        return mask_t'(4'hF) << (w * Cpw);
    endfunction

    function automatic int countWindows(input mask_t m);
        int n = 0;
        for (int w = 0; w < Windows; w++) begin
            if ((m & windowMask(w)) != '0) n++;
        end
        return n;
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vector_t vec[NumVec];
        int      base;
        int      k;
        int      seen0;

        vec[0] = '{"single_core5", mask_t'(1) << 5, 1};
        vec[1] = '{"all_ones", '1, 64};
        vec[2] = '{"two_windows", mask_t'(3) | (mask_t'(1) << 7), 2};
        vec[3] = '{"high_windows", (mask_t'(1) << 255) | (mask_t'(1) << 128), 2};
        vec[4] = '{"full_and_far", mask_t'(8'hF0) | (mask_t'(1) << 200), 2};
        vec[5] = '{"empty", '0, 0};
        vec[6] = '{"random", '0, 0};
        for (int i = 0; i < 5; i++) vec[6].req |= mask_t'(1) << $urandom_range(Cores - 1);
        vec[6].n_pulses = countWindows(vec[6].req);

        bus_if.wake_up_i = '0;
        idle(2);
        rst = 1'b0;
        checkOutput("reset_wake_up", bus_if.wake_up_o, '0);
        checkOutput("reset_busy", mask_t'(bus_if.busy_o), '0);

        for (int v = 0; v < NumVec; v++) begin
            doReset();
            base = cyc;
            k    = 0;
            for (int w = 0; w < Windows; w++) begin
                if ((vec[v].req & windowMask(w)) != '0) begin
                    expectPulse(base + 2 + Step * k, vec[v].req & windowMask(w));
                    k++;
                end
            end
            busy_from = base + 1;
            busy_to   = (k > 0) ? base + 2 + Step * (k - 1) : base;
            seen0     = pulse_seen;
            applyStimulus(vec[v].req);
            drain(vec[v].name, 300);
            idle(6);
            checkCount(vec[v].name, pulse_seen - seen0, vec[v].n_pulses);
        end

        // Wrap-around: park ptr at 63, then windows 63 and 0 pending; afterwards ptr must be 1.
        doReset();
        base = cyc;
        expectPulse(base + 2, mask_t'(1) << 248);
        busy_from = base + 1;
        busy_to   = base + 2;
        applyStimulus(mask_t'(1) << 248);
        idle(7);
        base = cyc;
        expectPulse(base + 2, windowMask(63));
        expectPulse(base + 6, mask_t'(1));
        busy_from = base + 1;
        busy_to   = base + 6;
        applyStimulus(windowMask(63) | mask_t'(1));
        drain("wrap", 50);
        idle(4);
        base = cyc;
        expectPulse(base + 2, mask_t'(1) << 4);
        expectPulse(base + 6, mask_t'(1));
        busy_from = base + 1;
        busy_to   = base + 6;
        applyStimulus((mask_t'(1) << 4) | mask_t'(1));
        drain("ptr_after_wrap", 50);
        idle(6);

        // Merge and re-request: core 1 at cycles 0, 1 and 2 yields pulses at 2 and 6 only.
        doReset();
        base = cyc;
        expectPulse(base + 2, mask_t'(2));
        expectPulse(base + 6, mask_t'(2));
        busy_from = base + 1;
        busy_to   = base + 6;
        seen0     = pulse_seen;
        applyStimulus(mask_t'(2));
        applyStimulus(mask_t'(2));
        applyStimulus(mask_t'(2));
        drain("merge", 50);
        idle(8);
        checkCount("merge", pulse_seen - seen0, 2);

        // Window 0 and 2 pending, all-ones request arriving at cycle 3.
        doReset();
        base = cyc;
        expectPulse(base + 2, mask_t'(1));
`ifdef WAKE_UP_SEQ_BROADCAST_EN
        expectPulse(base + 4, '1);
        busy_from = base + 1;
        busy_to   = base + 3;
`else
        for (int w = 1; w < Windows; w++) expectPulse(base + 6 + Step * (w - 1), windowMask(w));
        expectPulse(base + 6 + Step * 63, windowMask(0));
        busy_from = base + 1;
        busy_to   = base + 6 + Step * 63;
`endif
        seen0 = pulse_seen;
        applyStimulus(mask_t'(1) | (mask_t'(4'hF) << 8));
        idle(2);
        applyStimulus('1);
        drain("all_ones_late", 300);
        idle(10);
`ifdef WAKE_UP_SEQ_BROADCAST_EN
        checkCount("broadcast", pulse_seen - seen0, 2);
`else
        checkCount("all_ones_late", pulse_seen - seen0, 65);
`endif

        // Reset mid-operation: all ones at cycle 0, reset at cycle 10 kills the cycle-10 pulse.
        doReset();
        base = cyc;
        expectPulse(base + 2, windowMask(0));
        expectPulse(base + 6, windowMask(1));
        busy_from = base + 1;
        busy_to   = base + 9;
        seen0     = pulse_seen;
        applyStimulus('1);
        idle(9);
        doReset();
        idle(20);
        drain("reset_mid", 5);
        checkCount("reset_mid", pulse_seen - seen0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
